// File: rtl/li_mc_pkg.sv
// Shared widths for the multi-channel credit wrapper.
package li_mc_pkg;

    localparam int STAT_W = 16;

    function automatic int ch_width(input int num_ch);
        return ($clog2(num_ch) < 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int credit_width(input int out_credits);
        return $clog2(out_credits + 1);
    endfunction

endpackage

// File: rtl/li_chan_fifo.sv
// Per-channel FIFO, 2**FIFO_ADDR words, occupancy tracked by a FIFO_ADDR+1 bit count.
// Latency: a write is visible at rd_data the cycle after it lands; no write-to-read bypass.
// Backpressure: a write when full is dropped unless a read happens in the same cycle.
module li_chan_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_ADDR  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 2 ** FIFO_ADDR;
    localparam logic [FIFO_ADDR:0] FULL_CNT = (FIFO_ADDR + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_ADDR-1:0]  wr_ptr;
    logic [FIFO_ADDR-1:0]  rd_ptr;
    logic [FIFO_ADDR:0]    count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_ok   = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/li_mc_credit_wrapper.sv
// Merges NUM_CH buffered channels round-robin onto one credit-controlled output; LI_MC_STATS_EN adds stall counters.
// Latency: 2 cycles from i_valid to o_valid; one word per cycle sustained.
// Backpressure: issue stalls at zero downstream credits; writes to a full channel are dropped and flagged.
module li_mc_credit_wrapper
    import li_mc_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_CH      = 4,
    parameter  int FIFO_ADDR   = 4,
    parameter  int OUT_CREDITS = 16,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]            i_valid,
    output logic [NUM_CH-1:0]            o_increment_count,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [CH_W-1:0]              o_ch,
    output logic                         o_valid,
    input  logic                         i_increment_count,
    output logic [NUM_CH-1:0]            o_overflow
`ifdef LI_MC_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0]     o_stall_cnt
`endif
);

    localparam int CR_W = credit_width(OUT_CREDITS);

    logic [DATA_WIDTH-1:0] fifo_rd_data [NUM_CH];
    logic [NUM_CH-1:0]     fifo_empty;
    logic [NUM_CH-1:0]     fifo_full;
    logic [NUM_CH-1:0]     pop;
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  grant_vld;
    logic [CR_W-1:0]       credits;
    logic [CH_W-1:0]       arb_cand;
    int                    arb_j;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        li_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_ADDR  (FIFO_ADDR)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (i_valid[c]),
            .wr_data (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en   (pop[c]),
            .rd_data (fifo_rd_data[c]),
            .empty   (fifo_empty[c]),
            .full    (fifo_full[c])
        );
    end

    // Search starts one past the previous winner so every busy channel gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_j     = 0;
        arb_cand  = '0;
        pop       = '0;
        if (credits != '0) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                arb_j = int'(last_grant) + i;
                if (arb_j >= NUM_CH) begin
                    arb_j = arb_j - NUM_CH;
                end
                arb_cand = CH_W'(arb_j);
                if (!grant_vld && !fifo_empty[arb_cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = arb_cand;
                end
            end
        end
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_valid           <= 1'b0;
            o_data            <= '0;
            o_ch              <= '0;
            o_increment_count <= '0;
            o_overflow        <= '0;
            last_grant        <= CH_W'(NUM_CH - 1);
            credits           <= CR_W'(OUT_CREDITS);
        end else begin
            o_valid           <= grant_vld;
            o_increment_count <= pop;
            o_overflow        <= o_overflow | (i_valid & fifo_full & ~pop);
            if (grant_vld) begin
                o_data     <= fifo_rd_data[grant_idx];
                o_ch       <= grant_idx;
                last_grant <= grant_idx;
            end
            // Issue and return in the same cycle cancel; returns beyond the initial pool are ignored.
            if (grant_vld && !i_increment_count) begin
                credits <= credits - 1'b1;
            end else if (!grant_vld && i_increment_count && (credits < CR_W'(OUT_CREDITS))) begin
                credits <= credits + 1'b1;
            end
        end
    end

`ifdef LI_MC_STATS_EN
    logic [STAT_W-1:0] stall_cnt [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                stall_cnt[c] <= '0;
            end else if (!fifo_empty[c] && !pop[c] && (stall_cnt[c] != '1)) begin
                stall_cnt[c] <= stall_cnt[c] + 1'b1;
            end
        end
        assign o_stall_cnt[c*STAT_W +: STAT_W] = stall_cnt[c];
    end
`else
    // Stall statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_li_mc_credit_wrapper.sv
// Directed bench: dut_a uses the default configuration, dut_b has 2 credits and 4-deep channels.
module tb_li_mc_credit_wrapper;

    logic         clock = 1'b0;
    logic         rst_a;
    logic         rst_b;
    logic [127:0] a_data;
    logic [3:0]   a_valid;
    logic         a_inc;
    logic [3:0]   a_o_inc;
    logic [31:0]  a_o_data;
    logic [1:0]   a_o_ch;
    logic         a_o_valid;
    logic [3:0]   a_o_ovf;
    logic [127:0] b_data;
    logic [3:0]   b_valid;
    logic         b_inc;
    logic [3:0]   b_o_inc;
    logic [31:0]  b_o_data;
    logic [1:0]   b_o_ch;
    logic         b_o_valid;
    logic [3:0]   b_o_ovf;

    int checks = 0;
    int errors = 0;
    int nv;
    int got;

    always #5 clock = ~clock;

    li_mc_credit_wrapper dut_a (
        .clock             (clock),
        .reset             (rst_a),
        .i_data            (a_data),
        .i_valid           (a_valid),
        .o_increment_count (a_o_inc),
        .o_data            (a_o_data),
        .o_ch              (a_o_ch),
        .o_valid           (a_o_valid),
        .i_increment_count (a_inc),
        .o_overflow        (a_o_ovf)
    );

    li_mc_credit_wrapper #(
        .DATA_WIDTH  (32),
        .NUM_CH      (4),
        .FIFO_ADDR   (2),
        .OUT_CREDITS (2)
    ) dut_b (
        .clock             (clock),
        .reset             (rst_b),
        .i_data            (b_data),
        .i_valid           (b_valid),
        .o_increment_count (b_o_inc),
        .o_data            (b_o_data),
        .o_ch              (b_o_ch),
        .o_valid           (b_o_valid),
        .i_increment_count (b_inc),
        .o_overflow        (b_o_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_data = '0; a_valid = '0; a_inc = 1'b0;
        b_data = '0; b_valid = '0; b_inc = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_valid", a_o_valid, 0);
        chk("rst_data", a_o_data, 0);
        chk("rst_ch", a_o_ch, 0);
        chk("rst_inc", a_o_inc, 0);
        chk("rst_ovf", a_o_ovf, 0);
        chk("rst_credits", dut_a.credits, 16);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Single word on ch2: visible two cycles after it is presented
        a_data[64 +: 32] = 32'hA5; a_valid = 4'b0100;
        tick();
        a_valid = '0;
        chk("lat_c1_valid", a_o_valid, 0);
        tick();
        chk("lat_valid", a_o_valid, 1);
        chk("lat_data", a_o_data, 32'hA5);
        chk("lat_ch", a_o_ch, 2);
        chk("lat_inc", a_o_inc, 4'b0100);
        tick();
        chk("lat_valid_after", a_o_valid, 0);
        chk("lat_inc_after", a_o_inc, 0);

        // Round-robin order after a fresh reset
        rst_a = 1'b1; tick(); rst_a = 1'b0; tick();
        for (int c = 0; c < 4; c++) a_data[c*32 +: 32] = 32'h100 + c;
        a_valid = 4'hF;
        tick();
        for (int c = 0; c < 4; c++) a_data[c*32 +: 32] = 32'h200 + c;
        tick();
        a_valid = '0;
        for (int k = 0; k < 8; k++) begin
            chk("rr_valid", a_o_valid, 1);
            chk("rr_ch", a_o_ch, k % 4);
            chk("rr_data", a_o_data, ((k < 4) ? 32'h100 : 32'h200) + (k % 4));
            chk("rr_inc", a_o_inc, 64'(1) << (k % 4));
            tick();
        end
        chk("rr_done", a_o_valid, 0);
        chk("rr_credits", dut_a.credits, 8);

        // Stream on ch1 down to one credit; issue and return together keep it at one
        for (int cy = 0; cy < 14; cy++) begin
            a_valid = (cy < 10) ? 4'b0010 : 4'b0000;
            a_data[32 +: 32] = 32'h300 + cy;
            a_inc = (cy == 8) || (cy == 9);
            if (cy >= 2 && cy <= 11) begin
                chk("stream_valid", a_o_valid, 1);
                chk("stream_data", a_o_data, 32'h300 + cy - 2);
            end else begin
                chk("stream_idle", a_o_valid, 0);
            end
            if (cy >= 8 && cy <= 10) chk("stream_credit_one", dut_a.credits, 1);
            tick();
        end
        a_valid = '0; a_inc = 1'b0;
        chk("stream_credit_zero", dut_a.credits, 0);

        // Returns saturate at the initial pool
        a_inc = 1'b1;
        repeat (20) tick();
        a_inc = 1'b0;
        tick();
        chk("credit_saturate", dut_a.credits, 16);

        // Asynchronous reset with words queued and one in flight
        a_data[0 +: 32] = 32'h400; a_data[32 +: 32] = 32'h401; a_data[64 +: 32] = 32'h402;
        a_valid = 4'b0111;
        tick();
        a_valid = '0;
        tick();
        chk("pre_rst_valid", a_o_valid, 1);
        chk("pre_rst_ch", a_o_ch, 2);
        chk("pre_rst_data", a_o_data, 32'h402);
        #2 rst_a = 1'b1;
        #1;
        chk("arst_valid", a_o_valid, 0);
        chk("arst_data", a_o_data, 0);
        chk("arst_ch", a_o_ch, 0);
        chk("arst_inc", a_o_inc, 0);
        chk("arst_credits", dut_a.credits, 16);
        tick(); tick();
        rst_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_valid", a_o_valid, 0);
            chk("post_rst_inc", a_o_inc, 0);
        end
        chk("post_rst_credits", dut_a.credits, 16);

        // Two credits: only two of five words issue until a return arrives
        b_data[0 +: 32] = 32'hB0; b_data[32 +: 32] = 32'hC0; b_valid = 4'b0011;
        tick();
        chk("cred_c1_valid", b_o_valid, 0);
        b_data[0 +: 32] = 32'hB1; b_data[32 +: 32] = 32'hC1; b_valid = 4'b0011;
        tick();
        chk("cred_w0_valid", b_o_valid, 1);
        chk("cred_w0_ch", b_o_ch, 0);
        chk("cred_w0_data", b_o_data, 32'hB0);
        b_data[0 +: 32] = 32'hB2; b_valid = 4'b0001;
        tick();
        chk("cred_w1_valid", b_o_valid, 1);
        chk("cred_w1_ch", b_o_ch, 1);
        chk("cred_w1_data", b_o_data, 32'hC0);
        b_valid = '0;
        nv = 0;
        repeat (6) begin
            tick();
            if (b_o_valid) nv++;
        end
        chk("cred_stall_count", nv, 0);
        chk("cred_zero", dut_b.credits, 0);
        b_inc = 1'b1;
        tick();
        b_inc = 1'b0;
        chk("cred_ret_c1", b_o_valid, 0);
        tick();
        chk("cred_ret_valid", b_o_valid, 1);
        chk("cred_ret_ch", b_o_ch, 0);
        chk("cred_ret_data", b_o_data, 32'hB1);
        chk("cred_ret_inc", b_o_inc, 4'b0001);
        tick();
        chk("cred_ret_after", b_o_valid, 0);

        // Overflow on a 4-deep channel with credits exhausted
        rst_b = 1'b1; tick(); rst_b = 1'b0; tick();
        b_data[0 +: 32] = 32'hE0; b_valid = 4'b0001;
        tick();
        b_data[0 +: 32] = 32'hE1;
        tick();
        b_valid = '0;
        tick(); tick();
        chk("ovf_credits_zero", dut_b.credits, 0);
        for (int i = 0; i < 5; i++) begin
            b_data[32 +: 32] = 32'hD0 + i;
            b_valid = 4'b0010;
            tick();
            if (i == 3) chk("ovf_before", b_o_ovf, 4'b0000);
        end
        b_valid = '0;
        chk("ovf_set", b_o_ovf, 4'b0010);
        b_inc = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (b_o_valid) begin
                chk("ovf_drain_data", b_o_data, 32'hD0 + got);
                chk("ovf_drain_ch", b_o_ch, 1);
                got++;
            end
        end
        b_inc = 1'b0;
        chk("ovf_stored", got, 4);
        chk("ovf_sticky", b_o_ovf, 4'b0010);
        #2 rst_b = 1'b1;
        #1;
        chk("ovf_arst", b_o_ovf, 0);
        tick();
        rst_b = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
